// File: rtl/decode_execute_stage_if.sv
// Bundle between the fetch/decode register, writeback/forwarding sources and
// the decode/execute stage.
interface decode_execute_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] pc;
    logic             stall;
    logic             flush;
    logic             wb_regwrite;
    logic [3:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [WIDTH-1:0] fwd_mem;
    logic [1:0]       fwd_sel_a;
    logic [1:0]       fwd_sel_b;

    logic             id_memread;
    logic [WIDTH-1:0] ex_aluout;
    logic [WIDTH-1:0] ex_bout;
    logic [3:0]       ex_rd;
    logic             ex_zero;
    logic             ex_pos;
    logic             ex_branch_taken;
    logic [WIDTH-1:0] ex_target;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_regwrite;
    logic             ex_mem2reg;

    modport master (
        output ir, pc, stall, flush, wb_regwrite, wb_rd, wb_data,
               fwd_mem, fwd_sel_a, fwd_sel_b,
        input  id_memread, ex_aluout, ex_bout, ex_rd, ex_zero, ex_pos,
               ex_branch_taken, ex_target, ex_memread, ex_memwrite,
               ex_regwrite, ex_mem2reg
    );

    modport slave (
        input  ir, pc, stall, flush, wb_regwrite, wb_rd, wb_data,
               fwd_mem, fwd_sel_a, fwd_sel_b,
        output id_memread, ex_aluout, ex_bout, ex_rd, ex_zero, ex_pos,
               ex_branch_taken, ex_target, ex_memread, ex_memwrite,
               ex_regwrite, ex_mem2reg
    );
endinterface

// File: rtl/decode_execute_stage.sv
// Decode (control, register file, immediate), D/E pipeline register and
// execute (forwarding, ALU, flags, branch resolution) of the 16-bit pipeline.
module decode_execute_stage #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input logic                  clk,
    input logic                  rst,
    decode_execute_stage_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] aluin1;
        logic [1:0] aluin2;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       mem2reg;
        logic       branch;
        logic       jump;
        logic       bne;
    } ctrl_t;

    ctrl_t            ctrl_id;
    logic [1:0]       immgenop;
    logic [WIDTH-1:0] imm_id;
    logic [WIDTH-1:0] a_id;
    logic [WIDTH-1:0] b_id;
    logic [WIDTH-1:0] regs [NREGS];

    ctrl_t            ctrl_de;
    logic [WIDTH-1:0] pc_de;
    logic [WIDTH-1:0] a_de;
    logic [WIDTH-1:0] b_de;
    logic [WIDTH-1:0] imm_de;
    logic [3:0]       rd_de;

    logic [WIDTH-1:0] a_f;
    logic [WIDTH-1:0] b_f;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] alu;
    logic             zero;
    logic             taken;

    always_comb begin
        ctrl_id  = '0;
        immgenop = 2'b00;
        case (bus.ir[3:0])
            4'h0, 4'h1, 4'h2, 4'h3: begin
                ctrl_id.aluop    = bus.ir[1:0];
                ctrl_id.regwrite = 1'b1;
                ctrl_id.mem2reg  = 1'b1;
            end
            4'h4: begin
                ctrl_id.aluin2   = 2'b01;
                ctrl_id.regwrite = 1'b1;
                ctrl_id.mem2reg  = 1'b1;
            end
            4'h5: begin
                ctrl_id.aluin2   = 2'b01;
                ctrl_id.memread  = 1'b1;
                ctrl_id.regwrite = 1'b1;
            end
            4'h6: begin
                immgenop         = 2'b01;
                ctrl_id.aluin2   = 2'b01;
                ctrl_id.memwrite = 1'b1;
            end
            4'h7, 4'h8: begin
                immgenop       = 2'b01;
                ctrl_id.aluop  = 2'b01;
                ctrl_id.branch = 1'b1;
                ctrl_id.bne    = bus.ir[3];
            end
            4'h9: begin
                immgenop         = 2'b11;
                ctrl_id.aluin1   = 2'b10;
                ctrl_id.aluin2   = 2'b01;
                ctrl_id.regwrite = 1'b1;
                ctrl_id.mem2reg  = 1'b1;
            end
            4'hA: begin
                immgenop         = 2'b10;
                ctrl_id.aluin1   = 2'b01;
                ctrl_id.aluin2   = 2'b10;
                ctrl_id.jump     = 1'b1;
                ctrl_id.regwrite = 1'b1;
                ctrl_id.mem2reg  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (immgenop)
            2'b00:   imm_id = {{(WIDTH-4){bus.ir[15]}}, bus.ir[15:12]};
            2'b01:   imm_id = {{(WIDTH-4){bus.ir[7]}}, bus.ir[7:4]};
            2'b10:   imm_id = {{(WIDTH-8){bus.ir[15]}}, bus.ir[15:8]};
            default: imm_id = {bus.ir[15:8], {(WIDTH-8){1'b0}}};
        endcase
    end

    // Same-edge writeback is bypassed so decode sees the value being written.
    function automatic logic [WIDTH-1:0] rf_read(input logic [RW-1:0] sel);
        if (sel == '0)
            return '0;
        else if (bus.wb_regwrite && (bus.wb_rd == sel))
            return bus.wb_data;
        else
            return regs[sel];
    endfunction

    always_comb begin
        a_id = rf_read(bus.ir[11:8]);
        b_id = rf_read(bus.ir[15:12]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wb_regwrite && (bus.wb_rd != '0)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_de <= '0;
            pc_de   <= '0;
            a_de    <= '0;
            b_de    <= '0;
            imm_de  <= '0;
            rd_de   <= '0;
        end else if (bus.flush) begin
            ctrl_de <= '0;
            pc_de   <= '0;
            a_de    <= '0;
            b_de    <= '0;
            imm_de  <= '0;
            rd_de   <= '0;
        end else if (!bus.stall) begin
            ctrl_de <= ctrl_id;
            pc_de   <= bus.pc;
            a_de    <= a_id;
            b_de    <= b_id;
            imm_de  <= imm_id;
            rd_de   <= bus.ir[7:4];
        end
    end

    always_comb begin
        case (bus.fwd_sel_a)
            2'b01:   a_f = bus.fwd_mem;
            2'b10:   a_f = bus.wb_data;
            default: a_f = a_de;
        endcase
        case (bus.fwd_sel_b)
            2'b01:   b_f = bus.fwd_mem;
            2'b10:   b_f = bus.wb_data;
            default: b_f = b_de;
        endcase
        case (ctrl_de.aluin1)
            2'b00:   op1 = a_f;
            2'b01:   op1 = pc_de;
            default: op1 = '0;
        endcase
        case (ctrl_de.aluin2)
            2'b00:   op2 = b_f;
            2'b01:   op2 = imm_de;
            2'b10:   op2 = WIDTH'(2);
            default: op2 = '0;
        endcase
        case (ctrl_de.aluop)
            2'b00:   alu = op1 + op2;
            2'b01:   alu = op1 - op2;
            2'b10:   alu = op1 & op2;
            default: alu = op1 | op2;
        endcase
        zero  = (alu == '0);
        taken = ctrl_de.jump | (ctrl_de.branch & (ctrl_de.bne ? ~zero : zero));
    end

    assign bus.id_memread = ctrl_id.memread;

    // Outputs are forced low while reset is held, independent of the forwarding inputs.
    assign bus.ex_aluout       = rst ? alu : '0;
    assign bus.ex_bout         = rst ? b_f : '0;
    assign bus.ex_rd           = rst ? rd_de : '0;
    assign bus.ex_zero         = rst & zero;
    assign bus.ex_pos          = rst & ~alu[WIDTH-1] & ~zero;
    assign bus.ex_branch_taken = rst & taken;
    assign bus.ex_target       = rst ? (pc_de + (imm_de << 1)) : '0;
    assign bus.ex_memread      = rst & ctrl_de.memread;
    assign bus.ex_memwrite     = rst & ctrl_de.memwrite;
    assign bus.ex_regwrite     = rst & ctrl_de.regwrite;
    assign bus.ex_mem2reg      = rst & ctrl_de.mem2reg;
endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: directed vector table, hand sequences for
// stall/flush/reset, then random traffic against an instruction-level model.
module tb_decode_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_execute_stage_if bus ();
    decode_execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int nchecks = 0;
    int nfail   = 0;

    typedef struct packed {
        logic [15:0] alu;
        logic        alu_chk;
        logic [15:0] bout;
        logic [3:0]  rd;
        logic        zero;
        logic        pos;
        logic        taken;
        logic [15:0] target;
        logic        t_chk;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] a;
        logic [15:0] b;
    } infl_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [15:0] pc;
        logic [1:0]  fsa;
        logic [1:0]  fsb;
        logic [15:0] fmem;
        exp_t        e;
    } vec_t;

    logic [15:0] mrf [16];
    infl_t       de;
    vec_t        vecs [15];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] alu, input logic achk, input logic [15:0] bout,
                                input logic [3:0] rd, input logic zero, input logic pos,
                                input logic taken, input logic [15:0] target, input logic tchk,
                                input logic mr, input logic mw, input logic rw, input logic m2r);
        exp_t e;
        e = '{alu, achk, bout, rd, zero, pos, taken, target, tchk, mr, mw, rw, m2r};
        return e;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] reg_v,
                                         input logic [15:0] mem_v, input logic [15:0] wb_v);
        if (sel == 2'b01) return mem_v;
        if (sel == 2'b10) return wb_v;
        return reg_v;
    endfunction

    // Instruction-level semantics of whatever sits in execute.
    function automatic exp_t model_out(input infl_t d, input logic [1:0] fsa, input logic [1:0] fsb,
                                       input logic [15:0] fmem, input logic [15:0] wbd);
        exp_t e;
        logic [15:0] af, bf;
        int s4a, s4b, s8;
        e  = '0;
        af = pick(fsa, d.a, fmem, wbd);
        bf = pick(fsb, d.b, fmem, wbd);
        e.bout = bf;
        if (!d.valid) return e;
        e.rd = d.ir[7:4];
        s4a = int'($signed(d.ir[15:12]));
        s4b = int'($signed(d.ir[7:4]));
        s8  = int'($signed(d.ir[15:8]));
        e.alu_chk = 1'b1;
        case (d.ir[3:0])
            4'h0: begin e.alu = af + bf; e.rw = 1; e.m2r = 1; end
            4'h1: begin e.alu = af - bf; e.rw = 1; e.m2r = 1; end
            4'h2: begin e.alu = af & bf; e.rw = 1; e.m2r = 1; end
            4'h3: begin e.alu = af | bf; e.rw = 1; e.m2r = 1; end
            4'h4: begin e.alu = 16'(int'(af) + s4a); e.rw = 1; e.m2r = 1; end
            4'h5: begin e.alu = 16'(int'(af) + s4a); e.mr = 1; e.rw = 1; end
            4'h6: begin e.alu = 16'(int'(af) + s4b); e.mw = 1; end
            4'h7, 4'h8: begin
                e.alu    = af - bf;
                e.target = 16'(int'(d.pc) + 2 * s4b);
                e.t_chk  = 1'b1;
                e.taken  = (d.ir[3:0] == 4'h7) ? (af == bf) : (af != bf);
            end
            4'h9: begin e.alu = d.ir[15:8] * 16'd256; e.rw = 1; e.m2r = 1; end
            4'hA: begin
                e.alu    = d.pc + 16'd2;
                e.target = 16'(int'(d.pc) + 2 * s8);
                e.t_chk  = 1'b1;
                e.taken  = 1'b1;
                e.rw = 1; e.m2r = 1;
            end
            default: e.alu_chk = 1'b0;
        endcase
        if (e.alu_chk) begin
            e.zero = (e.alu == 16'd0);
            e.pos  = ($signed(e.alu) > 0);
        end
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        if (e.alu_chk) begin
            chk({tag, " aluout"}, bus.ex_aluout, e.alu);
            chk({tag, " zero"}, 16'(bus.ex_zero), 16'(e.zero));
            chk({tag, " pos"}, 16'(bus.ex_pos), 16'(e.pos));
        end
        if (e.t_chk) chk({tag, " target"}, bus.ex_target, e.target);
        chk({tag, " bout"}, bus.ex_bout, e.bout);
        chk({tag, " rd"}, 16'(bus.ex_rd), 16'(e.rd));
        chk({tag, " taken"}, 16'(bus.ex_branch_taken), 16'(e.taken));
        chk({tag, " memread"}, 16'(bus.ex_memread), 16'(e.mr));
        chk({tag, " memwrite"}, 16'(bus.ex_memwrite), 16'(e.mw));
        chk({tag, " regwrite"}, 16'(bus.ex_regwrite), 16'(e.rw));
        chk({tag, " mem2reg"}, 16'(bus.ex_mem2reg), 16'(e.m2r));
    endtask

    function automatic logic [15:0] rdm(input logic [3:0] r);
        if (r == 4'd0) return 16'd0;
        if (bus.wb_regwrite && bus.wb_rd == r) return bus.wb_data;
        return mrf[r];
    endfunction

    // One clock: the model captures/writes exactly as the pipeline should.
    task automatic tick();
        infl_t nxt;
        nxt = de;
        if (bus.flush) nxt = '0;
        else if (!bus.stall) nxt = '{1'b1, bus.ir, bus.pc, rdm(bus.ir[11:8]), rdm(bus.ir[15:12])};
        if (bus.wb_regwrite && bus.wb_rd != 4'd0) mrf[bus.wb_rd] = bus.wb_data;
        @(posedge clk);
        de = nxt;
        #1;
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [15:0] d);
        bus.ir = 16'h000B;
        bus.wb_regwrite = 1'b1;
        bus.wb_rd = r;
        bus.wb_data = d;
        tick();
        bus.wb_regwrite = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mrf[i] = 16'd0;
        de = '0;
    endtask

    initial begin
        bus.ir = 16'h0005; bus.pc = 16'd0; bus.stall = 0; bus.flush = 0;
        bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.fwd_mem = 16'h1234; bus.fwd_sel_a = 2'b01; bus.fwd_sel_b = 2'b01;
        model_reset();

        // Reset state
        #1;
        chk("rst aluout", bus.ex_aluout, 16'h0000);
        chk("rst bout", bus.ex_bout, 16'h0000);
        chk("rst taken", 16'(bus.ex_branch_taken), 16'h0);
        chk("rst regwrite", 16'(bus.ex_regwrite), 16'h0);
        chk("rst id_memread lw", 16'(bus.id_memread), 16'h1);
        bus.ir = 16'h000B;
        #1;
        chk("rst id_memread nop", 16'(bus.id_memread), 16'h0);
        bus.fwd_sel_a = 2'b00; bus.fwd_sel_b = 2'b00; bus.fwd_mem = 16'h0;
        @(negedge clk);
        rst = 1'b1;

        wb_write(4'd1, 16'h0007);
        wb_write(4'd2, 16'h1000);
        wb_write(4'd3, 16'h0005);
        wb_write(4'd4, 16'h0003);
        wb_write(4'd5, 16'h0007);
        wb_write(4'd6, 16'h1234);

        vecs[0]  = '{"ADD",     16'h4350, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h0008,1,16'h0003,4'h5,0,1,0,16'h0,0,0,0,1,1)};
        vecs[1]  = '{"SUB_fwd", 16'h0071, 16'h0000, 2'b01, 2'b00, 16'hFFFF, mk(16'hFFFF,1,16'h0000,4'h7,0,0,0,16'h0,0,0,0,1,1)};
        vecs[2]  = '{"AND",     16'h4382, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h0001,1,16'h0003,4'h8,0,1,0,16'h0,0,0,0,1,1)};
        vecs[3]  = '{"OR",      16'h4393, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h0007,1,16'h0003,4'h9,0,1,0,16'h0,0,0,0,1,1)};
        vecs[4]  = '{"BEQ_eq",  16'h51E7, 16'h0010, 2'b00, 2'b00, 16'h0000, mk(16'h0000,1,16'h0007,4'hE,1,0,1,16'h000C,1,0,0,0,0)};
        vecs[5]  = '{"BEQ_ne",  16'h31E7, 16'h0010, 2'b00, 2'b00, 16'h0000, mk(16'h0002,1,16'h0005,4'hE,0,1,0,16'h000C,1,0,0,0,0)};
        vecs[6]  = '{"BNE_eq",  16'h51E8, 16'h0010, 2'b00, 2'b00, 16'h0000, mk(16'h0000,1,16'h0007,4'hE,1,0,0,16'h000C,1,0,0,0,0)};
        vecs[7]  = '{"BNE_ne",  16'h31E8, 16'h0010, 2'b00, 2'b00, 16'h0000, mk(16'h0002,1,16'h0005,4'hE,0,1,1,16'h000C,1,0,0,0,0)};
        vecs[8]  = '{"JAL",     16'h08FA, 16'h0020, 2'b00, 2'b00, 16'h0000, mk(16'h0022,1,16'h0000,4'hF,0,1,1,16'h0030,1,0,0,1,1)};
        vecs[9]  = '{"LW",      16'h32A5, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h1003,1,16'h0005,4'hA,0,1,0,16'h0,0,1,0,1,0)};
        vecs[10] = '{"SW",      16'h6216, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h1001,1,16'h1234,4'h1,0,1,0,16'h0,0,0,1,0,0)};
        vecs[11] = '{"LUI",     16'hAB29, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'hAB00,1,16'h0000,4'h2,0,0,0,16'h0,0,0,0,1,1)};
        vecs[12] = '{"ADDI",    16'hF634, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h1233,1,16'h0000,4'h3,0,1,0,16'h0,0,0,0,1,1)};
        vecs[13] = '{"ADD_fwdb",16'h4350, 16'h0000, 2'b00, 2'b01, 16'h8000, mk(16'h8005,1,16'h8000,4'h5,0,0,0,16'h0,0,0,0,1,1)};
        vecs[14] = '{"NOP",     16'h123C, 16'h0000, 2'b00, 2'b00, 16'h0000, mk(16'h0000,0,16'h0007,4'h3,0,0,0,16'h0,0,0,0,0,0)};

        foreach (vecs[i]) begin
            bus.ir = vecs[i].ir; bus.pc = vecs[i].pc;
            bus.fwd_sel_a = 2'b00; bus.fwd_sel_b = 2'b00;
            tick();
            bus.fwd_sel_a = vecs[i].fsa; bus.fwd_sel_b = vecs[i].fsb; bus.fwd_mem = vecs[i].fmem;
            #1;
            check_all(vecs[i].name, vecs[i].e);
        end
        bus.fwd_sel_a = 2'b00; bus.fwd_sel_b = 2'b00; bus.pc = 16'd0;

        // Read-during-write bypass: ADD r1 = r11 + r0 while r11 is written
        bus.ir = 16'h0B10; bus.wb_regwrite = 1; bus.wb_rd = 4'd11; bus.wb_data = 16'h0042;
        tick();
        bus.wb_regwrite = 0;
        chk("bypass aluout", bus.ex_aluout, 16'h0042);

        // r0 is never written
        wb_write(4'd0, 16'h1234);
        bus.ir = 16'h0014;
        tick();
        chk("r0 aluout", bus.ex_aluout, 16'h0000);
        chk("r0 zero", 16'(bus.ex_zero), 16'h1);

        // Stall holds execute for three cycles
        bus.ir = 16'h4350;
        tick();
        chk("stall pre", bus.ex_aluout, 16'h0008);
        bus.stall = 1; bus.ir = 16'h4391;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall hold aluout", bus.ex_aluout, 16'h0008);
            chk("stall hold rd", 16'(bus.ex_rd), 16'h5);
        end
        bus.stall = 0;
        tick();
        chk("stall release aluout", bus.ex_aluout, 16'h0002);
        chk("stall release rd", 16'(bus.ex_rd), 16'h9);

        // Flush, and flush winning over stall
        bus.ir = 16'h32A5; bus.flush = 1;
        tick();
        chk("flush memread", 16'(bus.ex_memread), 16'h0);
        chk("flush regwrite", 16'(bus.ex_regwrite), 16'h0);
        chk("flush rd", 16'(bus.ex_rd), 16'h0);
        bus.flush = 0; bus.ir = 16'h08FA; bus.pc = 16'h0020;
        tick();
        chk("pre flush-stall taken", 16'(bus.ex_branch_taken), 16'h1);
        bus.flush = 1; bus.stall = 1;
        tick();
        chk("flush+stall taken", 16'(bus.ex_branch_taken), 16'h0);
        chk("flush+stall regwrite", 16'(bus.ex_regwrite), 16'h0);
        chk("flush+stall rd", 16'(bus.ex_rd), 16'h0);
        bus.flush = 0; bus.stall = 0;

        // Asynchronous reset mid-stream
        tick();
        chk("pre rst taken", 16'(bus.ex_branch_taken), 16'h1);
        @(negedge clk);
        rst = 0;
        #1;
        model_reset();
        chk("async rst aluout", bus.ex_aluout, 16'h0000);
        chk("async rst taken", 16'(bus.ex_branch_taken), 16'h0);
        chk("async rst target", bus.ex_target, 16'h0000);
        chk("async rst regwrite", 16'(bus.ex_regwrite), 16'h0);
        chk("async rst rd", 16'(bus.ex_rd), 16'h0);
        rst = 1;
        #1;
        chk("post rst taken", 16'(bus.ex_branch_taken), 16'h0);
        chk("post rst regwrite", 16'(bus.ex_regwrite), 16'h0);
        bus.ir = 16'h0350; bus.pc = 16'd0;
        tick();
        chk("post rst rf cleared", bus.ex_aluout, 16'h0000);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            exp_t e;
            bus.ir = 16'($urandom);
            bus.pc = 16'($urandom) & 16'hFFFE;
            bus.stall = ($urandom_range(0, 9) == 0);
            bus.flush = ($urandom_range(0, 11) == 0);
            bus.wb_regwrite = $urandom_range(0, 1);
            bus.wb_rd = 4'($urandom);
            bus.wb_data = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            #1;
            chk("rand id_memread", 16'(bus.id_memread), 16'(bus.ir[3:0] == 4'h5));
            tick();
            bus.fwd_sel_a = 2'($urandom);
            bus.fwd_sel_b = 2'($urandom);
            bus.fwd_mem = 16'($urandom);
            #1;
            e = model_out(de, bus.fwd_sel_a, bus.fwd_sel_b, bus.fwd_mem, bus.wb_data);
            check_all("rand", e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
